// File: rtl/rx_bit_sequencer.sv
// USB 1.1 receive bit sequencer: routes decoded bits to the stuff detector and
// byte shifter, drops stuffed zeros, and flags byte, stuffing and alignment events.
module rx_bit_sequencer #(
    parameter int BYTE_BITS = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic sample,
    input  logic d_orig,
    input  logic eop,
    input  logic start,
    input  logic bit_stuff,
    output logic det_shift_en,
    output logic shift_strobe,
    output logic byte_ready,
    output logic stuff_err,
    output logic align_err,
    output logic pkt_done,
    output logic busy
);

    localparam int CNT_W = (BYTE_BITS > 1) ? $clog2(BYTE_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_BITS - 1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RECEIVE  = 2'd1;
    localparam logic [1:0] ERR_WAIT = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             byte_ready_q, byte_ready_d;
    logic             stuff_err_q, stuff_err_d;
    logic             align_err_q, align_err_d;
    logic             pkt_done_q, pkt_done_d;

    // The detector must see every line bit, stuffed ones included.
    assign det_shift_en = (state_q == RECEIVE) & sample & ~eop;
    assign shift_strobe = det_shift_en & ~bit_stuff;
    assign busy         = (state_q == RECEIVE) | (state_q == ERR_WAIT);

    assign byte_ready = byte_ready_q;
    assign stuff_err  = stuff_err_q;
    assign align_err  = align_err_q;
    assign pkt_done   = pkt_done_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        byte_ready_d = 1'b0;
        stuff_err_d  = 1'b0;
        align_err_d  = 1'b0;
        pkt_done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RECEIVE;
                    cnt_d   = '0;
                end
            end
            RECEIVE: begin
                if (sample) begin
                    if (eop) begin
                        align_err_d = (cnt_q != '0);
                        pkt_done_d  = 1'b1;
                        state_d     = IDLE;
                        cnt_d       = '0;
                    end else if (bit_stuff && !d_orig) begin
                        cnt_d = cnt_q;
                    end else if (bit_stuff && d_orig) begin
                        stuff_err_d = 1'b1;
                        state_d     = ERR_WAIT;
                    end else if (cnt_q == LAST_BIT) begin
                        cnt_d        = '0;
                        byte_ready_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ERR_WAIT: begin
                if (sample && eop) begin
                    pkt_done_d = 1'b1;
                    state_d    = IDLE;
                    cnt_d      = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            byte_ready_q <= 1'b0;
            stuff_err_q  <= 1'b0;
            align_err_q  <= 1'b0;
            pkt_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            byte_ready_q <= byte_ready_d;
            stuff_err_q  <= stuff_err_d;
            align_err_q  <= align_err_d;
            pkt_done_q   <= pkt_done_d;
        end
    end

endmodule

// File: tb/tb_rx_bit_sequencer.sv
// Directed bench for rx_bit_sequencer: one sample per step, combinational
// enables checked in the sample cycle, registered pulses checked one cycle later.
module tb_rx_bit_sequencer;

    logic clk = 1'b0;
    logic n_rst;
    logic sample, d_orig, eop, start, bit_stuff;
    logic det_shift_en, shift_strobe, byte_ready;
    logic stuff_err, align_err, pkt_done, busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rx_bit_sequencer #(.BYTE_BITS(8)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .sample       (sample),
        .d_orig       (d_orig),
        .eop          (eop),
        .start        (start),
        .bit_stuff    (bit_stuff),
        .det_shift_en (det_shift_en),
        .shift_strobe (shift_strobe),
        .byte_ready   (byte_ready),
        .stuff_err    (stuff_err),
        .align_err    (align_err),
        .pkt_done     (pkt_done),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".det"}, det_shift_en, 1'b0);
        chk({tag, ".shift"}, shift_strobe, 1'b0);
        chk({tag, ".byte"}, byte_ready, 1'b0);
        chk({tag, ".serr"}, stuff_err, 1'b0);
        chk({tag, ".aerr"}, align_err, 1'b0);
        chk({tag, ".done"}, pkt_done, 1'b0);
        chk({tag, ".busy"}, busy, 1'b0);
    endtask

    // One bit period: sample high for one cycle, then one quiet cycle.
    task automatic step(input string tag, input logic d, input logic e,
                        input logic bs, input logic x_det, input logic x_sh,
                        input logic x_br, input logic x_se, input logic x_ae,
                        input logic x_pd, input logic x_busy);
        @(negedge clk);
        sample = 1'b1; d_orig = d; eop = e; bit_stuff = bs;
        #1;
        chk({tag, ".det"}, det_shift_en, x_det);
        chk({tag, ".shift"}, shift_strobe, x_sh);
        @(negedge clk);
        sample = 1'b0; d_orig = 1'b0; eop = 1'b0; bit_stuff = 1'b0;
        #1;
        chk({tag, ".det_q"}, det_shift_en, 1'b0);
        chk({tag, ".byte"}, byte_ready, x_br);
        chk({tag, ".serr"}, stuff_err, x_se);
        chk({tag, ".aerr"}, align_err, x_ae);
        chk({tag, ".done"}, pkt_done, x_pd);
        chk({tag, ".busy"}, busy, x_busy);
    endtask

    task automatic data_bit(input string tag, input logic d, input logic last);
        step(tag, d, 1'b0, 1'b0, 1'b1, 1'b1, last, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_start(input string tag, input logic x_busy_after);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk({tag, ".busy"}, busy, x_busy_after);
    endtask

    logic [7:0] pat;

    initial begin
        n_rst = 1'b0; sample = 1'b0; d_orig = 1'b0;
        eop = 1'b0; start = 1'b0; bit_stuff = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        n_rst = 1'b1;

        // eop and data in IDLE are ignored
        step("idle_eop", 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0);
        step("idle_bit", 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0);

        // start and sample together: that sample is not consumed
        @(negedge clk);
        start = 1'b1; sample = 1'b1; d_orig = 1'b1;
        #1;
        chk("start_samp.det", det_shift_en, 1'b0);
        chk("start_samp.shift", shift_strobe, 1'b0);
        @(negedge clk);
        start = 1'b0; sample = 1'b0; d_orig = 1'b0;
        #1;
        chk("start_samp.busy", busy, 1'b1);
        chk("start_samp.byte", byte_ready, 1'b0);

        // byte 1: 1,0,1,0,0,1,1,0
        pat = 8'b1010_0110;
        for (int i = 0; i < 8; i++)
            data_bit($sformatf("b1_%0d", i), pat[7-i], i == 7);

        // start while receiving is ignored; six ones, a stuffed zero, two bits
        do_start("restart_ign", 1'b1);
        for (int i = 0; i < 6; i++)
            data_bit($sformatf("ones_%0d", i), 1'b1, 1'b0);
        step("stuffed0", 1'b0, 1'b0, 1'b1, 1, 0, 0, 0, 0, 0, 1);
        data_bit("post_stuff0", 1'b1, 1'b0);
        data_bit("post_stuff1", 1'b0, 1'b1);

        // stuffing error, then ignored data, then EOP
        data_bit("pre_serr0", 1'b1, 1'b0);
        data_bit("pre_serr1", 1'b1, 1'b0);
        step("serr", 1'b1, 1'b0, 1'b1, 1, 0, 0, 1, 0, 0, 1);
        step("errw_bit", 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 1);
        step("errw_stuff", 1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0, 1);
        step("errw_eop", 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 1, 0);

        // 16 bits then clean EOP
        do_start("s16", 1'b1);
        for (int i = 0; i < 16; i++)
            data_bit($sformatf("b16_%0d", i), i[0], (i == 7) || (i == 15));
        step("eop16", 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 1, 0);

        // 11 bits then EOP mid-byte
        do_start("s11", 1'b1);
        for (int i = 0; i < 11; i++)
            data_bit($sformatf("b11_%0d", i), ~i[1], i == 7);
        step("eop11", 1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 1, 1, 0);

        // reset at bit 5 of a byte
        do_start("s_rst", 1'b1);
        for (int i = 0; i < 5; i++)
            data_bit($sformatf("brst_%0d", i), 1'b1, 1'b0);
        @(negedge clk);
        sample = 1'b1; d_orig = 1'b1;
        #2 n_rst = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        @(negedge clk);
        sample = 1'b0; d_orig = 1'b0;
        #1;
        chk_all_zero("mid_rst_hold");
        n_rst = 1'b1;
        step("post_rst0", 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
        step("post_rst1", 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
        do_start("s_after", 1'b1);
        for (int i = 0; i < 8; i++)
            data_bit($sformatf("baft_%0d", i), 1'b0, i == 7);
        step("eop_aft", 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 1, 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_bit_sequencer.md
Name: rx_bit_sequencer

Overview:
- Per-bit receive controller for the USB 1.1 receive path.
- Once per bit period it decides whether the decoded bit feeds the bit-stuff detector and the byte shift register, or is dropped as a stuffed zero. It also counts bits into bytes and flags stuffing and byte-alignment errors.
- It sits between the bit-timing/NRZI-decode front end and the receive control unit (RCU). It drives the stuff detector's shift enable and consumes that detector's flag.

Parameters:
- BYTE_BITS, 8, data bits per byte; bit counter width is clog2(BYTE_BITS).

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- sample  input  1  one-cycle strobe, once per USB bit period, from bit timer
- d_orig  input  1  NRZI-decoded bit, valid when sample=1
- eop  input  1  SE0/end-of-packet detected, valid when sample=1
- start  input  1  one-cycle pulse from RCU after SYNC; next sample carries first data bit
- bit_stuff  input  1  from stuff detector: previous six accepted bits were all 1
- det_shift_en  output  1  shift enable to stuff detector (combinational)
- shift_strobe  output  1  shift enable to byte shift register (combinational)
- byte_ready  output  1  registered pulse: BYTE_BITS data bits assembled
- stuff_err  output  1  registered pulse: seventh consecutive 1 seen
- align_err  output  1  registered pulse: EOP arrived mid-byte
- pkt_done  output  1  registered pulse: packet ended (clean or error)
- busy  output  1  high in RECEIVE or ERR_WAIT

Behaviour:
- States:
  - IDLE: start -> RECEIVE; clear bit_cnt.
  - RECEIVE: per-sample decisions below.
  - ERR_WAIT: ignore data until sample&eop -> IDLE.
- Reset (n_rst=0, async): state=IDLE, bit_cnt=0. byte_ready, stuff_err, align_err and pkt_done are all 0. busy=0.
- det_shift_en = (state==RECEIVE) & sample & ~eop. It is high for data bits and stuffed bits alike, so the detector sees every line bit.
- shift_strobe = det_shift_en & ~bit_stuff. It is the same cycle as sample, with zero latency.
- RECEIVE, sample=1, priority order:
  1. eop=1: no shifts. If bit_cnt!=0, pulse align_err. Pulse pkt_done and go to IDLE.
  2. bit_stuff=1 & d_orig=0: stuffed bit. Dropped: no shift_strobe, bit_cnt unchanged, stay in RECEIVE.
  3. bit_stuff=1 & d_orig=1: pulse stuff_err and go to ERR_WAIT. bit_cnt is not incremented.
  4. Otherwise, a data bit: bit_cnt+1. If bit_cnt==BYTE_BITS-1, wrap bit_cnt to 0 and pulse byte_ready.
- RECEIVE, sample=0: hold state and counter; no outputs asserted.
- ERR_WAIT, sample=1, eop=1: pulse pkt_done and go to IDLE. align_err is not pulsed.
- Registered pulses are exactly one cycle wide, asserted on the cycle after the triggering sample.
- start outside IDLE is ignored. start and sample in the same cycle as the IDLE->RECEIVE transition: that sample is not consumed.
- eop in IDLE is ignored.
- busy is a combinational decode of state.
- Reset asserted mid-packet returns the block to IDLE immediately; no pulses are emitted.

Test Plan:
- Reset, then start, then 8 samples with d_orig=1,0,1,0,0,1,1,0 and bit_stuff=0 -> 8 shift_strobe cycles; byte_ready pulses once, 1 cycle after the 8th sample; bit_cnt returns to 0.
- Start, 6 samples of 1 (bit_stuff modelled high after the 6th), then a sample with d_orig=0, then 2 more bits -> det_shift_en on 9 samples, shift_strobe on 8; byte_ready after the 9th sample.
- bit_stuff=1 and d_orig=1 on a sample -> stuff_err pulse next cycle; busy stays 1. Further samples produce no strobes. A later sample with eop -> pkt_done pulse, no align_err, busy=0.
- 16 data bits, then sample with eop=1 -> two byte_ready pulses, pkt_done only, no align_err.
- 11 data bits, then EOP -> align_err and pkt_done pulse together; state returns to IDLE.
- Assert n_rst=0 at bit 5 of a byte -> all outputs 0 immediately. After release, samples are ignored until start; the next byte is counted from bit 0.
